rx_protocol: RTL and testbench
==============================

RX_PROTOCOL -- requirements
Module: rx_protocol

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- RX_WIDTH, 8, received byte width; also the register address width.
- REG_DATA_WIDTH, 16, register data width; SHALL be an integer multiple of RX_WIDTH.
- TIMEOUT_CYCLES, 65535, maximum idle cycles allowed between bytes inside a frame.
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
REQ-003 Byte input port:
- rx_data  in  RX_WIDTH  received byte.
- rx_rdy  in  1  rx_data valid.
- rx_ack  out  1  byte consumed.
REQ-004 Register output ports:
- reg_addr  out  RX_WIDTH  register address.
- reg_data  out  REG_DATA_WIDTH  register value.
- reg_rdy  out  1  one-cycle write strobe.
REQ-005 Command and error ports, all one-cycle pulses:
- req_tr  out  1  trigger status requested.
- req_ch1  out  1  channel 1 data requested.
- req_ch2  out  1  channel 2 data requested.
- frame_err  out  1  malformed or timed-out frame.

Function
REQ-006 Byte acceptance: a byte SHALL be accepted in cycle N when rx_rdy=1 and rx_ack=0.
REQ-007 rx_ack is registered: it SHALL be 1 in cycle N+1 only. rx_rdy SHALL be ignored in any cycle where rx_ack=1.
REQ-008 Header byte decode: 0x01 register write; 0x02 trigger status request; 0x03 channel 1 request; 0x04 channel 2 request; any other value invalid.
REQ-009 States: ST_IDLE, ST_ADDR, ST_DATA, ST_ERR.
REQ-010 ST_IDLE transitions on an accepted header:
- 0x01 -> ST_ADDR.
- 0x02/0x03/0x04 -> pulse req_tr/req_ch1/req_ch2 in N+1; stay in ST_IDLE.
- invalid -> ST_ERR.
REQ-011 ST_ADDR: the accepted byte SHALL be latched as the pending address; go to ST_DATA; clear byte counter.
REQ-012 ST_DATA: accepted bytes fill the pending data LSB-first, i.e. byte k lands in bits [k*RX_WIDTH +: RX_WIDTH]. After byte REG_DATA_WIDTH/RX_WIDTH-1 is accepted, go to ST_IDLE.
REQ-013 Write-out timing: reg_addr/reg_data SHALL update and reg_rdy SHALL pulse in cycle N+1 of the last data byte. reg_addr/reg_data SHALL hold until the next completed write.
REQ-014 Partial frames: reg_addr/reg_data SHALL NOT change on an incomplete frame.
REQ-015 ST_ERR: frame_err SHALL pulse for exactly one cycle, then the FSM returns to ST_IDLE. A byte presented during that cycle SHALL NOT be accepted.
REQ-016 Timeout counter: in ST_ADDR/ST_DATA it SHALL reset on each accepted byte and increment otherwise.
REQ-017 Timeout action: on reaching TIMEOUT_CYCLES, go to ST_ERR and discard the partial frame.
REQ-018 Counter widths: timeout counter width is $clog2(TIMEOUT_CYCLES+1); byte counter width is max(1, $clog2(REG_DATA_WIDTH/RX_WIDTH)).
REQ-019 Pulse exclusivity: at most one of reg_rdy, req_tr, req_ch1, req_ch2, frame_err SHALL be 1 in any cycle.

Reset
REQ-020 Reset values (rst=0): state=ST_IDLE, rx_ack=0, reg_rdy=0, req_tr=0, req_ch1=0, req_ch2=0, frame_err=0, reg_addr=0, reg_data=0, both counters=0.
REQ-021 Reset mid-frame SHALL discard the partial frame with no strobe.
REQ-022 Reset SHALL be applied asynchronously and released synchronously to clk.

Verification
REQ-023 Register write: bytes 0x01, 0x05, 0x34, 0x12 -> one reg_rdy pulse with reg_addr=0x05, reg_data=0x1234; four rx_ack pulses.
REQ-024 Commands: bytes 0x02, 0x03, 0x04 -> req_tr, req_ch1, req_ch2 each pulse once, in order, one cycle after acceptance; no reg_rdy.
REQ-025 Invalid header: byte 0x7F -> frame_err pulse; next frame 0x01,0x00,0xAA,0x55 -> reg_data=0x55AA.
REQ-026 Timeout: TIMEOUT_CYCLES=10; send 0x01, 0x09, then hold rx_rdy=0 for 10 cycles -> frame_err, no reg_rdy, reg_addr unchanged.
REQ-027 Reset mid-frame: send 0x01, 0x07, 0xEE, then assert rst -> all outputs at reset values; afterwards 0x02 -> req_tr pulse.
REQ-028 Back-to-back: rx_rdy held at 1 continuously -> each byte acked exactly once, one acceptance every 2 cycles.

Source files
------------

// File: rtl/rx_protocol.sv
// Byte-stream command decoder: turns header/address/data byte frames into
// register write strobes, command request pulses and frame error pulses.
module rx_protocol #(
  parameter int RX_WIDTH       = 8,
  parameter int REG_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RX_WIDTH-1:0]       rx_data,
  input  logic                      rx_rdy,
  output logic                      rx_ack,
  output logic [RX_WIDTH-1:0]       reg_addr,
  output logic [REG_DATA_WIDTH-1:0] reg_data,
  output logic                      reg_rdy,
  output logic                      req_tr,
  output logic                      req_ch1,
  output logic                      req_ch2,
  output logic                      frame_err
);

  localparam int NBYTES = REG_DATA_WIDTH / RX_WIDTH;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TCW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [TCW-1:0] TO_LIMIT  = TCW'(TIMEOUT_CYCLES);

  localparam logic [RX_WIDTH-1:0] HDR_WRITE = RX_WIDTH'(1);
  localparam logic [RX_WIDTH-1:0] HDR_TRIG  = RX_WIDTH'(2);
  localparam logic [RX_WIDTH-1:0] HDR_CH1   = RX_WIDTH'(3);
  localparam logic [RX_WIDTH-1:0] HDR_CH2   = RX_WIDTH'(4);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]                state;
  logic [TCW-1:0]            tcnt;
  logic [TCW-1:0]            tcnt_inc;
  logic [BCW-1:0]            bcnt;
  logic [RX_WIDTH-1:0]       pend_addr;
  logic [REG_DATA_WIDTH-1:0] pend_data;
  logic [REG_DATA_WIDTH-1:0] data_next;
  logic                      accept;

  // The error cycle refuses bytes so a frame never starts during frame_err.
  assign accept   = rx_rdy & ~rx_ack & (state != ST_ERR);
  assign tcnt_inc = tcnt + TCW'(1);

  always_comb begin
    data_next = pend_data;
    data_next[int'(bcnt) * RX_WIDTH +: RX_WIDTH] = rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      pend_addr <= '0;
      pend_data <= '0;
      rx_ack    <= 1'b0;
      reg_addr  <= '0;
      reg_data  <= '0;
      reg_rdy   <= 1'b0;
      req_tr    <= 1'b0;
      req_ch1   <= 1'b0;
      req_ch2   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_ack    <= accept;
      reg_rdy   <= 1'b0;
      req_tr    <= 1'b0;
      req_ch1   <= 1'b0;
      req_ch2   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          tcnt <= '0;
          if (accept) begin
            case (rx_data)
              HDR_WRITE: state   <= ST_ADDR;
              HDR_TRIG:  req_tr  <= 1'b1;
              HDR_CH1:   req_ch1 <= 1'b1;
              HDR_CH2:   req_ch2 <= 1'b1;
              default: begin
                state     <= ST_ERR;
                frame_err <= 1'b1;
              end
            endcase
          end
        end
        ST_ADDR: begin
          if (accept) begin
            pend_addr <= rx_data;
            bcnt      <= '0;
            tcnt      <= '0;
            state     <= ST_DATA;
          end else if (tcnt_inc == TO_LIMIT) begin
            state     <= ST_ERR;
            frame_err <= 1'b1;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        ST_DATA: begin
          if (accept) begin
            tcnt      <= '0;
            pend_data <= data_next;
            if (bcnt == LAST_BYTE) begin
              reg_addr <= pend_addr;
              reg_data <= data_next;
              reg_rdy  <= 1'b1;
              bcnt     <= '0;
              state    <= ST_IDLE;
            end else begin
              bcnt <= bcnt + BCW'(1);
            end
          end else if (tcnt_inc == TO_LIMIT) begin
            state     <= ST_ERR;
            frame_err <= 1'b1;
            tcnt      <= '0;
            bcnt      <= '0;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        default: begin
          state <= ST_IDLE;
          tcnt  <= '0;
          bcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_protocol.sv
// Scoreboard bench for rx_protocol: expected pulses are queued as frames are
// driven and matched against the DUT's strobes as they appear.
module tb_rx_protocol;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        rx_ack;
  logic [7:0]  reg_addr;
  logic [15:0] reg_data;
  logic        reg_rdy;
  logic        req_tr;
  logic        req_ch1;
  logic        req_ch2;
  logic        frame_err;

  rx_protocol #(
    .RX_WIDTH      (8),
    .REG_DATA_WIDTH(16),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .rx_ack   (rx_ack),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .reg_rdy  (reg_rdy),
    .req_tr   (req_tr),
    .req_ch1  (req_ch1),
    .req_ch2  (req_ch2),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_WR  = 1;
  localparam int K_TR  = 2;
  localparam int K_CH1 = 3;
  localparam int K_CH2 = 4;
  localparam int K_ERR = 5;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [15:0] data;
    bit          with_ack;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] tx_q[$];
  int         checks = 0;
  int         errors = 0;
  int         ack_cnt = 0;
  int         bytes_sent = 0;
  int         cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] addr, input logic [15:0] data,
                           input bit with_ack);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.with_ack = with_ack;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: sample half a cycle after the active edge.
  always @(negedge clk) begin
    int   npulse;
    int   kind;
    ev_t  e;
    if (rst) begin
      if (rx_ack) ack_cnt++;
      npulse = int'(reg_rdy) + int'(req_tr) + int'(req_ch1) + int'(req_ch2) + int'(frame_err);
      if (npulse != 0) begin
        check("pulse_excl", (npulse <= 1) ? 32'd1 : 32'd0, 32'd1);
        kind = reg_rdy ? K_WR : req_tr ? K_TR : req_ch1 ? K_CH1 : req_ch2 ? K_CH2 : K_ERR;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", kind, 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", kind, e.kind);
          if (e.kind == K_WR) begin
            check("reg_addr", {24'd0, reg_addr}, {24'd0, e.addr});
            check("reg_data", {16'd0, reg_data}, {16'd0, e.data});
          end
          if (e.with_ack) check("pulse_latency", {31'd0, rx_ack}, 32'd1);
        end
      end
    end
  end

  // Holds rx_rdy high across the whole queue; each byte is advanced once acked.
  task automatic send_all();
    int  prev_ack_cyc;
    bit  got;
    bit  first;
    first = 1'b1;
    prev_ack_cyc = 0;
    @(negedge clk);
    while (tx_q.size() > 0) begin
      rx_data = tx_q.pop_front();
      rx_rdy  = 1'b1;
      bytes_sent++;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (rx_ack) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) check("ack_timeout", 32'd0, 32'd1);
      else begin
        if (!first) check("ack_spacing", cyc - prev_ack_cyc, 32'd2);
        prev_ack_cyc = cyc;
        first = 1'b0;
      end
    end
    rx_rdy = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check({tag, "_drain"}, exp_q.size(), 32'd0);
    repeat (5) @(negedge clk);
    check({tag, "_acks"}, ack_cnt, bytes_sent);
  endtask

  initial begin
    rst     = 1'b0;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_addr", {24'd0, reg_addr}, 32'd0);
    check("rst_data", {16'd0, reg_data}, 32'd0);
    check("rst_pulses", {26'd0, rx_ack, reg_rdy, req_tr, req_ch1, req_ch2, frame_err}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Register write
    expect_ev(K_WR, 8'h05, 16'h1234, 1'b1);
    tx_q = '{8'h01, 8'h05, 8'h34, 8'h12};
    send_all();
    drain("write");

    // Commands in order
    expect_ev(K_TR, 8'h00, 16'h0000, 1'b1);
    expect_ev(K_CH1, 8'h00, 16'h0000, 1'b1);
    expect_ev(K_CH2, 8'h00, 16'h0000, 1'b1);
    tx_q = '{8'h02, 8'h03, 8'h04};
    send_all();
    drain("cmds");

    // Invalid header then a good frame
    expect_ev(K_ERR, 8'h00, 16'h0000, 1'b1);
    tx_q = '{8'h7F};
    send_all();
    drain("invalid");
    expect_ev(K_WR, 8'h00, 16'h55AA, 1'b1);
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'h55};
    send_all();
    drain("after_err");

    // Timeout inside a frame: error, no write, outputs keep the last write
    expect_ev(K_ERR, 8'h00, 16'h0000, 1'b0);
    tx_q = '{8'h01, 8'h09};
    send_all();
    drain("timeout");
    check("timeout_addr_hold", {24'd0, reg_addr}, 32'h00);
    check("timeout_data_hold", {16'd0, reg_data}, 32'h55AA);

    // Reset mid-frame
    tx_q = '{8'h01, 8'h07, 8'hEE};
    send_all();
    #2 rst = 1'b0;
    #1;
    check("midrst_addr", {24'd0, reg_addr}, 32'd0);
    check("midrst_data", {16'd0, reg_data}, 32'd0);
    check("midrst_pulses", {26'd0, rx_ack, reg_rdy, req_tr, req_ch1, req_ch2, frame_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expect_ev(K_TR, 8'h00, 16'h0000, 1'b1);
    tx_q = '{8'h02};
    send_all();
    drain("post_rst");
    check("post_rst_data", {16'd0, reg_data}, 32'd0);

    // Back-to-back: write then command with rx_rdy never dropped
    expect_ev(K_WR, 8'h10, 16'hBEEF, 1'b1);
    expect_ev(K_CH1, 8'h00, 16'h0000, 1'b1);
    tx_q = '{8'h01, 8'h10, 8'hEF, 8'hBE, 8'h03};
    send_all();
    drain("b2b");
    check("b2b_addr_hold", {24'd0, reg_addr}, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
